// File: rtl/perip_pump.sv
// rtl/perip_pump.sv - memory-mapped soft-start PWM pump driver with max-run watchdog
// Optional dry-well lockout enabled by defining PUMP_DRY_LOCK_EN.
module perip_pump #(
    parameter int PWM_DIV     = 4,
    parameter int RAMP_CYCLES = 25000,
    parameter int TICK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    input  logic        dry,
    output logic        pump_pwm
);

    localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PWM_DIV - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RUN       = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               enable_q, enable_d;
    logic [7:0]         target_q, target_d;
    logic [15:0]        maxrun_q, maxrun_d;
    logic               fault_to_q, fault_to_d;
    logic               fault_dry_q, fault_dry_d;
    logic [7:0]         cur_duty_q, cur_duty_d;
    logic [RAMP_W-1:0]  ramp_cnt_q, ramp_cnt_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [15:0]        run_ticks_q, run_ticks_d;
    logic [DIV_W-1:0]   pwm_div_q, pwm_div_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic               pwm_q, pwm_d;
    logic [31:0]        d_out_q, d_out_d;

    logic        wr_en, rd_en, fault_clear, running, ramp_step;
    logic        to_hit, dry_hit, dry_s;
    logic [7:0]  goal;
    logic [31:0] status;
    logic        unused_bus;

`ifdef PUMP_DRY_LOCK_EN
    logic dry_meta_q, dry_sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dry_meta_q <= 1'b0;
            dry_sync_q <= 1'b0;
        end else begin
            dry_meta_q <= dry;
            dry_sync_q <= dry_meta_q;
        end
    end

    assign dry_s = dry_sync_q;
`else
    logic unused_dry;
    assign unused_dry = dry;
    assign dry_s      = 1'b0;
`endif

    assign unused_bus  = ^{addr[31:4], addr[1:0], d_in[31:16]};
    assign wr_en       = cs & wr;
    assign rd_en       = cs & rd;
    assign fault_clear = wr_en && (addr[3:2] == 2'd0) && d_in[1];
    assign running     = (state_q == S_RAMP_UP) || (state_q == S_RUN) || (state_q == S_RAMP_DOWN);
    assign ramp_step   = (ramp_cnt_q == RAMP_LAST);
    // Disabling steers every ramp toward zero, so one goal drives both directions.
    assign goal        = enable_q ? target_q : 8'd0;
    assign to_hit      = running && (maxrun_q != 16'd0) && (run_ticks_q == maxrun_q);
    assign dry_hit     = running && dry_s;
    assign status      = {13'd0, state_q, cur_duty_q, 5'd0, fault_dry_q, fault_to_q, running};

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        target_d    = target_q;
        maxrun_d    = maxrun_q;
        fault_to_d  = fault_to_q;
        fault_dry_d = fault_dry_q;
        cur_duty_d  = cur_duty_q;
        ramp_cnt_d  = ramp_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        run_ticks_d = run_ticks_q;
        pwm_div_d   = pwm_div_q;
        pwm_cnt_d   = pwm_cnt_q;
        d_out_d     = d_out_q;

        if (wr_en) begin
            case (addr[3:2])
                2'd0: if (state_q != S_FAULT) enable_d = d_in[0];
                2'd1: target_d = d_in[7:0];
                2'd2: maxrun_d = d_in[15:0];
                default: ;
            endcase
        end

        if (rd_en) begin
            case (addr[3:2])
                2'd0:    d_out_d = {31'd0, enable_q};
                2'd1:    d_out_d = {24'd0, target_q};
                2'd2:    d_out_d = {16'd0, maxrun_q};
                default: d_out_d = status;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (enable_q && (target_q != 8'd0)) state_d = S_RAMP_UP;
            end
            S_RUN: begin
                if (cur_duty_q != goal) state_d = (goal > cur_duty_q) ? S_RAMP_UP : S_RAMP_DOWN;
            end
            S_RAMP_UP, S_RAMP_DOWN: begin
                ramp_cnt_d = ramp_step ? '0 : ramp_cnt_q + 1'b1;
                if (ramp_step) begin
                    if (cur_duty_q < goal)      cur_duty_d = cur_duty_q + 8'd1;
                    else if (cur_duty_q > goal) cur_duty_d = cur_duty_q - 8'd1;
                end
                // Direction is re-evaluated every cycle so a retarget can never overshoot.
                if (cur_duty_d == goal)     state_d = (goal == 8'd0) ? S_IDLE : S_RUN;
                else if (cur_duty_d < goal) state_d = S_RAMP_UP;
                else                        state_d = S_RAMP_DOWN;
            end
            S_FAULT: begin
                if (fault_clear) begin
                    fault_to_d  = 1'b0;
                    fault_dry_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d != S_RAMP_UP) && (state_d != S_RAMP_DOWN)) ramp_cnt_d = '0;

        if (running) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d  = '0;
                run_ticks_d = run_ticks_q + 16'd1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end else begin
            tick_cnt_d  = '0;
            run_ticks_d = '0;
        end

        // Protection overrides any same-cycle bus write.
        if (to_hit || dry_hit) begin
            state_d     = S_FAULT;
            fault_to_d  = fault_to_q | to_hit;
            fault_dry_d = fault_dry_q | dry_hit;
            cur_duty_d  = 8'd0;
            enable_d    = 1'b0;
            ramp_cnt_d  = '0;
            tick_cnt_d  = '0;
            run_ticks_d = '0;
        end

        if (pwm_div_q == DIV_LAST) begin
            pwm_div_d = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end else begin
            pwm_div_d = pwm_div_q + 1'b1;
        end

        pwm_d = (state_d == S_FAULT) ? 1'b0 : (pwm_cnt_q < cur_duty_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            target_q    <= 8'd0;
            maxrun_q    <= 16'd0;
            fault_to_q  <= 1'b0;
            fault_dry_q <= 1'b0;
            cur_duty_q  <= 8'd0;
            ramp_cnt_q  <= '0;
            tick_cnt_q  <= '0;
            run_ticks_q <= 16'd0;
            pwm_div_q   <= '0;
            pwm_cnt_q   <= 8'd0;
            pwm_q       <= 1'b0;
            d_out_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            target_q    <= target_d;
            maxrun_q    <= maxrun_d;
            fault_to_q  <= fault_to_d;
            fault_dry_q <= fault_dry_d;
            cur_duty_q  <= cur_duty_d;
            ramp_cnt_q  <= ramp_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            run_ticks_q <= run_ticks_d;
            pwm_div_q   <= pwm_div_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pwm_q       <= pwm_d;
            d_out_q     <= d_out_d;
        end
    end

    assign pump_pwm = pwm_q;
    assign d_out    = d_out_q;

endmodule

// File: tb/tb_perip_pump.sv
// tb/tb_perip_pump.sv - directed self-checking bench for perip_pump
module tb_perip_pump;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] d_in;
    logic        cs;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;
    logic        dry;
    logic        pump_pwm;

    int cyc = 0;
    int passes = 0;
    int fails = 0;
    int total = 0;

    perip_pump #(
        .PWM_DIV(1),
        .RAMP_CYCLES(4),
        .TICK_CYCLES(100)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .d_in(d_in),
        .cs(cs),
        .addr(addr),
        .rd(rd),
        .wr(wr),
        .d_out(d_out),
        .dry(dry),
        .pump_pwm(pump_pwm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
        cs = 1'b1; wr = 1'b1; addr = 32'h0043_0000 | {28'd0, off}; d_in = data;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
        cs = 1'b1; rd = 1'b1; addr = 32'h0043_0000 | {28'd0, off};
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        data = d_out;
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, output logic ok,
                              output logic [31:0] st, output int max_duty);
        int start;
        start = cyc; ok = 1'b0; st = 32'd0; max_duty = 0;
        while (!ok && (cyc - start) < budget) begin
            bus_read(4'hC, st);
            if (int'(st[15:8]) > max_duty) max_duty = int'(st[15:8]);
            if (st[18:16] == code) ok = 1'b1;
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            if (pump_pwm) n++;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        ok;
        int          t0, n, mx;

        cs = 1'b0; rd = 1'b0; wr = 1'b0; d_in = 32'd0; addr = 32'd0; dry = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_pwm", 32'(pump_pwm), 32'd0);
        chk("rst_dout", d_out, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        bus_read(4'hC, v); chk("rst_status", v, 32'd0);
        bus_read(4'h0, v); chk("rst_ctrl", v, 32'd0);
        bus_read(4'h4, v); chk("rst_duty", v, 32'd0);
        bus_read(4'h8, v); chk("rst_maxrun", v, 32'd0);
        bus_write(4'h8, 32'h0001_2345);
        bus_read(4'h8, v); chk("maxrun_mask", v, 32'h0000_2345);
        bus_write(4'h8, 32'd0);
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'hC, v); chk("status_ro", v, 32'd0);

        // Soft start to duty 8.
        bus_write(4'h4, 32'd8);
        bus_write(4'h0, 32'd1);
        t0 = cyc;
        @(negedge clk);
        bus_read(4'hC, v); chk("up_state", {29'd0, v[18:16]}, 32'd1);
        wait_state(3'd2, 80, ok, v, mx);
        chk("up_reach_run", 32'(ok), 32'd1);
        chk("up_time_in_range", 32'((cyc - t0) >= 28 && (cyc - t0) <= 40), 32'd1);
        chk("run_status", v, 32'h0002_0801);
        bus_read(4'h0, v); chk("ctrl_enabled", v, 32'd1);
        count_high(n); chk("pwm_high_d8", 32'(n), 32'd8);

        // Soft stop.
        bus_write(4'h0, 32'd0);
        t0 = cyc;
        @(negedge clk);
        bus_read(4'hC, v); chk("down_state", {29'd0, v[18:16]}, 32'd3);
        wait_state(3'd0, 80, ok, v, mx);
        chk("down_reach_idle", 32'(ok), 32'd1);
        chk("down_time_in_range", 32'((cyc - t0) >= 28 && (cyc - t0) <= 40), 32'd1);
        chk("idle_status", v, 32'd0);
        count_high(n); chk("pwm_high_idle", 32'(n), 32'd0);

        // Max-run watchdog: 3 ticks of 100 cycles.
        bus_write(4'h8, 32'd3);
        bus_write(4'h4, 32'd200);
        bus_write(4'h0, 32'd1);
        t0 = cyc;
        wait_state(3'd4, 400, ok, v, mx);
        chk("to_reach_fault", 32'(ok), 32'd1);
        chk("to_time_in_range", 32'((cyc - t0) >= 296 && (cyc - t0) <= 312), 32'd1);
        chk("to_status", v, 32'h0004_0002);
        count_high(n); chk("pwm_high_fault", 32'(n), 32'd0);
        bus_write(4'h0, 32'd1);
        @(negedge clk);
        bus_read(4'hC, v); chk("fault_enable_ignored", v, 32'h0004_0002);
        bus_read(4'h0, v); chk("fault_ctrl_cleared", v, 32'd0);
        bus_write(4'h0, 32'd2);
        bus_read(4'hC, v); chk("fault_clear_status", v, 32'd0);
        bus_write(4'h8, 32'd0);

        // Dry sensor in RUN.
        bus_write(4'h4, 32'd8);
        bus_write(4'h0, 32'd1);
        wait_state(3'd2, 80, ok, v, mx);
        chk("dry_reach_run", 32'(ok), 32'd1);
        dry = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(4'hC, v);
`ifdef PUMP_DRY_LOCK_EN
        chk("dry_status", v, 32'h0004_0004);
`else
        chk("dry_status", v, 32'h0002_0801);
`endif
        dry = 1'b0;
        repeat (3) @(negedge clk);
`ifdef PUMP_DRY_LOCK_EN
        bus_write(4'h0, 32'd2);
        bus_read(4'hC, v); chk("dry_cleared", v, 32'd0);
`else
        bus_write(4'h0, 32'd0);
        wait_state(3'd0, 80, ok, v, mx);
        chk("dry_stop_idle", 32'(ok), 32'd1);
`endif

        // Retarget mid-ramp at cur_duty 5.
        bus_write(4'h4, 32'd20);
        bus_write(4'h0, 32'd1);
        repeat (21) @(negedge clk);
        bus_write(4'h4, 32'd3);
        @(negedge clk);
        bus_read(4'hC, v); chk("retarget_down", v, 32'h0003_0501);
        wait_state(3'd2, 80, ok, v, mx);
        chk("retarget_run", 32'(ok), 32'd1);
        chk("retarget_max_le6", 32'(mx <= 6), 32'd1);
        chk("retarget_final", v, 32'h0002_0301);

        // Read-back masking and hold, then asynchronous reset.
        bus_write(4'h4, 32'h0000_01AB);
        bus_read(4'h4, v); chk("duty_readback", v, 32'h0000_00AB);
        repeat (3) @(negedge clk);
        chk("dout_hold", d_out, 32'h0000_00AB);
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pump_pwm), 32'd0);
        chk("async_rst_dout", d_out, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus_read(4'hC, v); chk("post_rst_status", v, 32'd0);
        bus_read(4'h4, v); chk("post_rst_duty", v, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
